microprogram_sequencer: RTL and testbench
=========================================

// Module: microprogram_sequencer
// PURPOSE
//  Next-state sequencer of the microprogrammed control unit. Registers the 7-bit control state that addresses the microstore.
//  Computes the next state from microinstruction fields, the decoded IR opcode/funct and status conditions (MOC, ALU flags).
//  Supports increment, jump, conditional branch, wait-on-condition with timeout, and a 1-deep micro-call/return.
// PARAMETERS
//  STATE_W      7    width of control state / microstore address
//  RESET_STATE  0    state entered on reset and on reserved ns_sel
//  TRAP_STATE   5    state entered on illegal instruction or MOC timeout
//  MOC_TIMEOUT  16   max cycles held in COND_WAIT with cond false; 0 = no timeout
// PORTS
//  clk          in   1        system clock, all logic on rising edge
//  reset        in   1        synchronous, active-high
//  opcode       in   6        IR[31:26]
//  funct        in   6        IR[5:0], used only when opcode==0
//  mem_moc      in   1        memory operation complete
//  alu_z        in   1        ALU zero flag
//  alu_n        in   1        ALU negative flag
//  ns_sel       in   3        next-state mode from current microinstruction
//  cr           in   7        target state field from current microinstruction
//  cond_sel     in   2        0=mem_moc 1=alu_z 2=alu_n 3=const 1
//  cond_inv     in   1        invert selected condition
//  state        out  7        registered current state -> microstore address
//  illegal_op   out  1        registered 1-cycle pulse, undecodable instruction
//  mem_timeout  out  1        registered 1-cycle pulse, COND_WAIT expired
//  waiting      out  1        comb: ns_sel==WAIT and cond==0 (state held)
// BEHAVIOUR
//  - Reset (sync, highest priority, also mid-wait/mid-call): state=RESET_STATE, ret_reg=RESET_STATE,
//    wait_cnt=0, illegal_op=0, mem_timeout=0. Reset-high at any edge overrides all other updates.
//  - cond = mux(cond_sel) ^ cond_inv. One microstep per clock; next state visible on state 1 cycle after edge.
//  - inc = state+1 modulo 2^STATE_W (127 -> 0).
//  - ns_sel: 0 ENCODE: state<=enc(opcode,funct); no table hit -> TRAP_STATE and illegal_op=1 for 1 cycle.
//            1 INCR: state<=inc.
//            2 JUMP: state<=cr.
//            3 BRANCH: state<= cond ? cr : inc.
//            4 WAIT: cond -> state<=inc, wait_cnt<=0; else hold state, wait_cnt++;
//              if MOC_TIMEOUT!=0 and wait_cnt==MOC_TIMEOUT-1 with cond 0 -> state<=TRAP_STATE,
//              mem_timeout=1 for 1 cycle, wait_cnt<=0. cond true on the expiry cycle wins (no timeout).
//            5 CALL: state<=cr, ret_reg<=inc (overwrites any pending return; 1-deep).
//            6 RETURN: state<=ret_reg, ret_reg<=RESET_STATE.
//            7 reserved: state<=RESET_STATE.
//  - wait_cnt cleared whenever ns_sel!=WAIT. Width clog2(MOC_TIMEOUT+1), saturates, never wraps.
//  - illegal_op/mem_timeout are 0 on all cycles except the one where state becomes TRAP_STATE for that cause.
// STRUCTURE
//  - Shared package usparams_pkg: ns_sel codes (NS_ENCODE..NS_RSVD), cond_sel codes,
//    opcode/funct constants, encoder table (opcode,funct)->state.
//  - Sub-module mips_state_encoder (comb): opcode,funct -> {hit, state[6:0]}.
//    Required entries: R-type funct 6'h21 ADDU->7'd6, R-type funct 6'h23 SUBU->7'd17, opcode 6'h23 LW->7'd7,
//    opcode 6'h2B SW->7'd13, opcode 6'h04 BEQ->7'd16.
//  - Top: state reg, ret_reg, wait_cnt, next-state mux, pulse flops.
// TESTING
//  1 reset=1 two edges, ns_sel=1 -> state=0, pulses 0; release, ns_sel=1 x3 -> state 1,2,3.
//  2 state=127, ns_sel=INCR -> state=0; ns_sel=JUMP cr=30 -> state=30.
//  3 ns_sel=ENCODE opcode=6'h23 -> 7; opcode=0 funct=6'h21 -> 6; opcode=6'h3F -> state=5, illegal_op one cycle.
//  4 ns_sel=WAIT cond_sel=0, mem_moc low 3 cycles then high -> state held 3 cycles, waiting=1, then state+1.
//  5 WAIT with mem_moc stuck low, MOC_TIMEOUT=16 -> after 16 cycles state=5, mem_timeout=1 for exactly 1 cycle.
//  6 at state 8, CALL cr=20 -> state=20; RETURN -> 9; RETURN again -> 0; reset mid-WAIT -> state 0, wait_cnt 0.

Source files
------------

// File: rtl/usparams_pkg.sv
// Shared microprogram-sequencer definitions: next-state modes, condition selects,
// MIPS opcode/funct constants and the instruction-to-microstate dispatch table.
package usparams_pkg;

  typedef enum logic [2:0] {
    NS_ENCODE = 3'd0,
    NS_INCR   = 3'd1,
    NS_JUMP   = 3'd2,
    NS_BRANCH = 3'd3,
    NS_WAIT   = 3'd4,
    NS_CALL   = 3'd5,
    NS_RETURN = 3'd6,
    NS_RSVD   = 3'd7
  } ns_sel_e;

  typedef enum logic [1:0] {
    CS_MOC   = 2'd0,
    CS_ALU_Z = 2'd1,
    CS_ALU_N = 2'd2,
    CS_ONE   = 2'd3
  } cond_sel_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [6:0] ST_ADDU = 7'd6;
  localparam logic [6:0] ST_LW   = 7'd7;
  localparam logic [6:0] ST_SW   = 7'd13;
  localparam logic [6:0] ST_BEQ  = 7'd16;
  localparam logic [6:0] ST_SUBU = 7'd17;

  typedef struct packed {
    logic       hit;
    logic [6:0] state;
  } enc_result_t;

  // Dispatch table: first microstate of each supported instruction.
  function automatic enc_result_t enc_lookup(input logic [5:0] opcode,
                                             input logic [5:0] funct);
    enc_result_t r;
    r.hit   = 1'b1;
    r.state = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: r.state = ST_ADDU;
          FN_SUBU: r.state = ST_SUBU;
          default: r.hit   = 1'b0;
        endcase
      end
      OP_LW:   r.state = ST_LW;
      OP_SW:   r.state = ST_SW;
      OP_BEQ:  r.state = ST_BEQ;
      default: r.hit   = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mips_state_encoder.sv
// Combinational instruction decoder: maps IR opcode/funct to the first
// microstate of that instruction, with a hit flag for decodable encodings.
module mips_state_encoder
  import usparams_pkg::*;
#(
  parameter int STATE_W = 7
) (
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  output logic               hit,
  output logic [STATE_W-1:0] state
);

  enc_result_t r;

  assign r     = enc_lookup(opcode, funct);
  assign hit   = r.hit;
  assign state = STATE_W'(r.state);

endmodule

// File: rtl/microprogram_sequencer.sv
// Next-state sequencer for the microprogrammed control unit: holds the microstore
// address and steps it by increment, jump, branch, wait-with-timeout or call/return.
module microprogram_sequencer
  import usparams_pkg::*;
#(
  parameter int                 STATE_W     = 7,
  parameter logic [STATE_W-1:0] RESET_STATE = '0,
  parameter logic [STATE_W-1:0] TRAP_STATE  = STATE_W'(5),
  parameter int                 MOC_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               mem_moc,
  input  logic               alu_z,
  input  logic               alu_n,
  input  logic [2:0]         ns_sel,
  input  logic [STATE_W-1:0] cr,
  input  logic [1:0]         cond_sel,
  input  logic               cond_inv,
  output logic [STATE_W-1:0] state,
  output logic               illegal_op,
  output logic               mem_timeout,
  output logic               waiting
);

  localparam bit HAS_TIMEOUT = (MOC_TIMEOUT > 0);
  localparam int CNT_W = HAS_TIMEOUT ? $clog2(MOC_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = HAS_TIMEOUT ? CNT_W'(MOC_TIMEOUT - 1) : '0;

  ns_sel_e            mode;
  logic               cond_raw;
  logic               cond;
  logic               enc_hit;
  logic [STATE_W-1:0] enc_state;
  logic [STATE_W-1:0] inc;
  logic [STATE_W-1:0] ret_reg;
  logic [CNT_W-1:0]   wait_cnt;

  logic [STATE_W-1:0] state_next;
  logic [STATE_W-1:0] ret_next;
  logic [CNT_W-1:0]   cnt_next;
  logic               illegal_next;
  logic               timeout_next;

  mips_state_encoder #(
    .STATE_W (STATE_W)
  ) u_encoder (
    .opcode (opcode),
    .funct  (funct),
    .hit    (enc_hit),
    .state  (enc_state)
  );

  assign mode = ns_sel_e'(ns_sel);
  assign inc  = state + STATE_W'(1);

  always_comb begin
    cond_raw = 1'b1;
    case (cond_sel_e'(cond_sel))
      CS_MOC:   cond_raw = mem_moc;
      CS_ALU_Z: cond_raw = alu_z;
      CS_ALU_N: cond_raw = alu_n;
      default:  cond_raw = 1'b1;
    endcase
  end

  assign cond    = cond_raw ^ cond_inv;
  assign waiting = (mode == NS_WAIT) && !cond;

  // NOTE: every output of this block is given a default before the case so no
  // path leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next   = state;
    ret_next     = ret_reg;
    cnt_next     = '0;
    illegal_next = 1'b0;
    timeout_next = 1'b0;
    case (mode)
      NS_ENCODE: begin
        if (enc_hit) begin
          state_next = enc_state;
        end else begin
          state_next   = TRAP_STATE;
          illegal_next = 1'b1;
        end
      end
      NS_INCR:   state_next = inc;
      NS_JUMP:   state_next = cr;
      NS_BRANCH: state_next = cond ? cr : inc;
      NS_WAIT: begin
        if (cond) begin
          state_next = inc;
        end else if (HAS_TIMEOUT && (wait_cnt == CNT_LAST)) begin
          // Condition still false on the last allowed cycle: give up and trap.
          state_next   = TRAP_STATE;
          timeout_next = 1'b1;
        end else begin
          cnt_next = (wait_cnt == '1) ? wait_cnt : wait_cnt + CNT_W'(1);
        end
      end
      NS_CALL: begin
        state_next = cr;
        ret_next   = inc;
      end
      NS_RETURN: begin
        state_next = ret_reg;
        ret_next   = RESET_STATE;
      end
      default: state_next = RESET_STATE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RESET_STATE;
      ret_reg     <= RESET_STATE;
      wait_cnt    <= '0;
      illegal_op  <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_next;
      ret_reg     <= ret_next;
      wait_cnt    <= cnt_next;
      illegal_op  <= illegal_next;
      mem_timeout <= timeout_next;
    end
  end

endmodule

// File: tb/tb_microprogram_sequencer.sv
// Self-checking bench for microprogram_sequencer: directed scenarios followed by
// randomized microinstruction streams, compared against a behavioural model.
module tb_microprogram_sequencer;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_moc;
  logic       alu_z;
  logic       alu_n;
  logic [2:0] ns_sel;
  logic [6:0] cr;
  logic [1:0] cond_sel;
  logic       cond_inv;
  logic [6:0] state;
  logic       illegal_op;
  logic       mem_timeout;
  logic       waiting;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: microstore address, pending return, cycles spent waiting.
  int m_state = 0;
  int m_ret   = 0;
  int m_held  = 0;
  bit m_ill   = 1'b0;
  bit m_to    = 1'b0;

  localparam int TIMEOUT = 16;
  localparam int TRAP    = 5;

  microprogram_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .funct       (funct),
    .mem_moc     (mem_moc),
    .alu_z       (alu_z),
    .alu_n       (alu_n),
    .ns_sel      (ns_sel),
    .cr          (cr),
    .cond_sel    (cond_sel),
    .cond_inv    (cond_inv),
    .state       (state),
    .illegal_op  (illegal_op),
    .mem_timeout (mem_timeout),
    .waiting     (waiting)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_enc(input int op, input int fn);
    if (op == 'h00 && fn == 'h21) return 6;
    if (op == 'h00 && fn == 'h23) return 17;
    if (op == 'h23) return 7;
    if (op == 'h2B) return 13;
    if (op == 'h04) return 16;
    return -1;
  endfunction

  function automatic bit model_cond(input int cs, input bit ci, input bit moc,
                                    input bit z, input bit n);
    bit c;
    case (cs)
      0:       c = moc;
      1:       c = z;
      2:       c = n;
      default: c = 1'b1;
    endcase
    return c ^ ci;
  endfunction

  // Apply one microinstruction, check waiting before the edge, advance the
  // model across the edge and check the registered outputs after it.
  task automatic step(input string tag, input bit r, input int ns, input int c,
                      input int cs, input bit ci, input bit moc, input bit z,
                      input bit n, input int op, input int fn);
    bit cnd;
    int e;
    int nxt;
    reset    = r;
    ns_sel   = 3'(ns);
    cr       = 7'(c);
    cond_sel = 2'(cs);
    cond_inv = ci;
    mem_moc  = moc;
    alu_z    = z;
    alu_n    = n;
    opcode   = 6'(op);
    funct    = 6'(fn);
    cnd = model_cond(cs, ci, moc, z, n);
    #1;
    check({tag, "/waiting"}, 32'(waiting), 32'(ns == 4 && !cnd));
    @(posedge clk);
    if (r) begin
      m_state = 0; m_ret = 0; m_held = 0; m_ill = 1'b0; m_to = 1'b0;
    end else begin
      m_ill = 1'b0;
      m_to  = 1'b0;
      nxt   = (m_state + 1) % 128;
      if (ns != 4) m_held = 0;
      case (ns)
        0: begin
          e = model_enc(op, fn);
          if (e < 0) begin m_state = TRAP; m_ill = 1'b1; end
          else m_state = e;
        end
        1: m_state = nxt;
        2: m_state = c;
        3: m_state = cnd ? c : nxt;
        4: begin
          if (cnd) begin
            m_state = nxt; m_held = 0;
          end else if (m_held + 1 == TIMEOUT) begin
            m_state = TRAP; m_to = 1'b1; m_held = 0;
          end else begin
            m_held++;
          end
        end
        5: begin m_ret = nxt; m_state = c; end
        6: begin m_state = m_ret; m_ret = 0; end
        default: m_state = 0;
      endcase
    end
    #1;
    check({tag, "/state"},       32'(state),       32'(m_state));
    check({tag, "/illegal_op"},  32'(illegal_op),  32'(m_ill));
    check({tag, "/mem_timeout"}, 32'(mem_timeout), 32'(m_to));
  endtask

  task automatic go(input string tag, input int ns, input int c);
    step(tag, 1'b0, ns, c, 3, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic enc(input string tag, input int op, input int fn);
    step(tag, 1'b0, 0, 0, 3, 1'b0, 1'b0, 1'b0, 1'b0, op, fn);
  endtask

  task automatic wait_moc(input string tag, input bit moc);
    step(tag, 1'b0, 4, 0, 0, 1'b0, moc, 1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    int ns, c, cs, op, fn;
    bit r, ci, moc, z, n;

    // Reset dominates, then plain increments.
    step("rst0", 1'b1, 1, 0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    step("rst1", 1'b1, 1, 0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    go("inc1", 1, 0);
    go("inc2", 1, 0);
    go("inc3", 1, 0);

    // Wraparound and jump.
    go("jmp127", 2, 127);
    go("wrap", 1, 0);
    go("jmp30", 2, 30);

    // Instruction dispatch, including undecodable encodings.
    enc("enc_lw", 'h23, 0);
    enc("enc_addu", 'h00, 'h21);
    enc("enc_subu", 'h00, 'h23);
    enc("enc_sw", 'h2B, 'h3F);
    enc("enc_beq", 'h04, 0);
    enc("enc_ill3f", 'h3F, 0);
    go("post_ill", 1, 0);
    enc("enc_illr", 'h00, 'h20);
    go("post_illr", 2, 40);

    // Conditional branches on ALU flags, with and without inversion.
    step("br_z_taken", 1'b0, 3, 50, 1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    step("br_n_fall", 1'b0, 3, 60, 2, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    step("br_n_inv", 1'b0, 3, 60, 2, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    step("br_moc_inv", 1'b0, 3, 90, 0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);

    // Wait on MOC: held three cycles, then advance.
    go("jmp70", 2, 70);
    for (int i = 0; i < 3; i++) wait_moc($sformatf("wait_lo%0d", i), 1'b0);
    wait_moc("wait_hi", 1'b1);

    // MOC never arrives: trap after the timeout, pulse lasts one cycle.
    for (int i = 0; i < TIMEOUT; i++) wait_moc($sformatf("to%0d", i), 1'b0);
    go("post_to", 1, 0);

    // One-deep call/return.
    go("jmp8", 2, 8);
    go("call20", 5, 20);
    go("ret1", 6, 0);
    go("ret2", 6, 0);
    go("rsvd", 7, 99);

    // Reset in the middle of a wait clears the wait counter.
    go("jmp100", 2, 100);
    for (int i = 0; i < 5; i++) wait_moc($sformatf("prewait%0d", i), 1'b0);
    step("rst_wait", 1'b1, 4, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < TIMEOUT; i++) wait_moc($sformatf("postrst%0d", i), 1'b0);

    // Randomized microinstruction streams.
    for (int i = 0; i < 600; i++) begin
      r   = ($urandom_range(0, 63) == 0);
      ns  = int'($urandom_range(0, 7));
      c   = int'($urandom_range(0, 127));
      cs  = int'($urandom_range(0, 3));
      ci  = ($urandom_range(0, 3) == 0);
      moc = ($urandom_range(0, 7) == 0);
      z   = 1'($urandom);
      n   = 1'($urandom);
      case ($urandom_range(0, 5))
        0:       op = 'h23;
        1:       op = 'h2B;
        2:       op = 'h04;
        3, 4:    op = 'h00;
        default: op = int'($urandom_range(0, 63));
      endcase
      case ($urandom_range(0, 2))
        0:       fn = 'h21;
        1:       fn = 'h23;
        default: fn = int'($urandom_range(0, 63));
      endcase
      step($sformatf("rnd%0d", i), r, ns, c, cs, ci, moc, z, n, op, fn);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
